// File: rtl/ecc_smul_seq.sv
// Scalar-multiplication sequencer: scans a KW-bit scalar MSB-first and issues
// EC_DBL / EC_ADD commands to the EC datapath over the ec_en/ec_rdy handshake.
// Supports constant-time mode (dummy adds), leading-zero skip, a per-operation
// watchdog, an operation counter and sticky error reporting.
module ecc_smul_seq #(
    parameter int KW     = 256,
    parameter int TO_CYC = 4096,
    parameter int OPW    = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  clr,
    input  logic                  ct_mode,
    input  logic [KW-1:0]         k_in,
    output logic                  rdy,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  acc_init,
    output logic [2:0]            ec_op,
    output logic                  ec_en,
    output logic                  ec_commit,
    input  logic                  ec_rdy,
    output logic [$clog2(KW)-1:0] bit_idx,
    output logic [OPW-1:0]        op_cnt
);

    localparam int IW = $clog2(KW);
    localparam int WW = $clog2(TO_CYC + 1);

    localparam logic [2:0] EC_DBL = 3'b101;
    localparam logic [2:0] EC_ADD = 3'b100;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SKIP,
        S_INIT,
        S_DBL_ISS,
        S_DBL_WAIT,
        S_ADD_ISS,
        S_ADD_WAIT,
        S_NEXT,
        S_FIN
    } state_t;

    state_t          state, state_nx;
    logic [KW-1:0]   k_reg;
    logic            ct_reg;
    logic [IW-1:0]   idx;
    logic [OPW-1:0]  cnt;
    logic            err_reg;
    logic [WW-1:0]   wd;

    logic            ld;
    logic            idx_dec;
    logic            cnt_inc;
    logic            set_err;
    logic            wd_clr;
    logic            cur_bit;
    logic            wait_first;
    logic            wd_expired;
    logic            in_wait;

    assign cur_bit    = k_reg[idx];
    assign wait_first = (wd == '0);
    assign wd_expired = (wd == WW'(TO_CYC - 1));
    assign in_wait    = (state == S_DBL_WAIT) || (state == S_ADD_WAIT);

    // Next-state decode and command outputs; clr overrides everything last.
    always_comb begin
        state_nx  = state;
        ld        = 1'b0;
        idx_dec   = 1'b0;
        cnt_inc   = 1'b0;
        set_err   = 1'b0;
        wd_clr    = 1'b0;
        ec_en     = 1'b0;
        ec_commit = 1'b0;
        ec_op     = 3'b000;
        case (state)
            S_IDLE: begin
                if (start) begin
                    ld = 1'b1;
                    if ((k_in == '0) || (ct_mode && !k_in[KW-1])) begin
                        set_err  = 1'b1;
                        state_nx = S_FIN;
                    end else if (ct_mode) begin
                        state_nx = S_INIT;
                    end else begin
                        state_nx = S_SKIP;
                    end
                end
            end
            S_SKIP: begin
                if (cur_bit) state_nx = S_INIT;
                else         idx_dec  = 1'b1;
            end
            S_INIT: begin
                if (idx == '0) begin
                    state_nx = S_FIN;
                end else begin
                    idx_dec  = 1'b1;
                    state_nx = S_DBL_ISS;
                end
            end
            S_DBL_ISS: begin
                ec_op = EC_DBL;
                if (ec_rdy) begin
                    ec_en     = 1'b1;
                    ec_commit = 1'b1;
                    cnt_inc   = 1'b1;
                    wd_clr    = 1'b1;
                    state_nx  = S_DBL_WAIT;
                end
            end
            S_DBL_WAIT: begin
                ec_op = EC_DBL;
                // ec_rdy in the first wait cycle may still reflect the
                // previous command, so it is not taken as completion.
                if (!wait_first) begin
                    if (ec_rdy) begin
                        state_nx = (cur_bit || ct_reg) ? S_ADD_ISS : S_NEXT;
                    end else if (wd_expired) begin
                        set_err  = 1'b1;
                        state_nx = S_FIN;
                    end
                end
            end
            S_ADD_ISS: begin
                ec_op = EC_ADD;
                if (ec_rdy) begin
                    ec_en     = 1'b1;
                    ec_commit = cur_bit;
                    cnt_inc   = 1'b1;
                    wd_clr    = 1'b1;
                    state_nx  = S_ADD_WAIT;
                end
            end
            S_ADD_WAIT: begin
                ec_op = EC_ADD;
                if (!wait_first) begin
                    if (ec_rdy) begin
                        state_nx = S_NEXT;
                    end else if (wd_expired) begin
                        set_err  = 1'b1;
                        state_nx = S_FIN;
                    end
                end
            end
            S_NEXT: begin
                if (idx == '0) begin
                    state_nx = S_FIN;
                end else begin
                    idx_dec  = 1'b1;
                    state_nx = S_DBL_ISS;
                end
            end
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (clr) begin
            state_nx  = S_IDLE;
            ld        = 1'b0;
            idx_dec   = 1'b0;
            cnt_inc   = 1'b0;
            set_err   = 1'b0;
            wd_clr    = 1'b0;
            ec_en     = 1'b0;
            ec_commit = 1'b0;
        end
    end

    // State, scalar, bit index, op counter, sticky error and watchdog registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            k_reg   <= '0;
            ct_reg  <= 1'b0;
            idx     <= '0;
            cnt     <= '0;
            err_reg <= 1'b0;
            wd      <= '0;
        end else begin
            state <= state_nx;
            if (clr) begin
                idx     <= '0;
                cnt     <= '0;
                err_reg <= 1'b0;
                wd      <= '0;
            end else begin
                if (ld) begin
                    k_reg   <= k_in;
                    ct_reg  <= ct_mode;
                    idx     <= IW'(KW - 1);
                    cnt     <= '0;
                    err_reg <= set_err;
                end else begin
                    if (idx_dec) idx <= idx - 1'b1;
                    if (cnt_inc && (cnt != '1)) cnt <= cnt + 1'b1;
                    if (set_err) err_reg <= 1'b1;
                end
                if (wd_clr)       wd <= '0;
                else if (in_wait) wd <= wd + 1'b1;
            end
        end
    end

    assign rdy      = (state == S_IDLE);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_FIN);
    assign acc_init = (state == S_INIT);
    assign err      = err_reg;
    assign op_cnt   = cnt;
    assign bit_idx  = idx;

endmodule

// File: tb/tb_ecc_smul_seq.sv
// Self-checking bench for ecc_smul_seq (KW=8, TO_CYC=16): a behavioural model
// derives the command list per scalar; one compare process checks every cycle.
module tb_ecc_smul_seq;

    localparam int KW  = 8;
    localparam int TO  = 16;
    localparam int OPW = 10;

    logic                  clk = 1'b0;
    logic                  rst, start, clr, ct_mode, ec_rdy;
    logic [KW-1:0]         k_in;
    logic                  rdy, busy, done, err, acc_init, ec_en, ec_commit;
    logic [2:0]            ec_op;
    logic [$clog2(KW)-1:0] bit_idx;
    logic [OPW-1:0]        op_cnt;

    ecc_smul_seq #(.KW(KW), .TO_CYC(TO), .OPW(OPW)) dut (
        .clk(clk), .rst(rst), .start(start), .clr(clr), .ct_mode(ct_mode),
        .k_in(k_in), .rdy(rdy), .busy(busy), .done(done), .err(err),
        .acc_init(acc_init), .ec_op(ec_op), .ec_en(ec_en), .ec_commit(ec_commit),
        .ec_rdy(ec_rdy), .bit_idx(bit_idx), .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state
    logic [3:0] exp_q[$];
    int         exp_cnt, exp_init, got_init, issued, done_cnt;
    logic       exp_err;
    bit         active = 1'b0;

    // datapath model controls
    bit         dp_hang = 1'b0;
    bit         dp_rand = 1'b0;
    int         dp_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    // Expected command list: double for every bit below the starting bit,
    // followed by an add when the bit is set (or always in constant-time mode).
    task automatic build(input logic [KW-1:0] k, input logic ct);
        int top;
        exp_q.delete();
        exp_init = 0;
        exp_err  = 1'b0;
        exp_cnt  = 0;
        if (k == 0 || (ct && !k[KW-1])) begin
            exp_err = 1'b1;
            return;
        end
        top = KW - 1;
        if (!ct) while (!k[top]) top--;
        exp_init = 1;
        for (int i = top - 1; i >= 0; i--) begin
            exp_q.push_back({3'b101, 1'b1});
            if (ct || k[i]) exp_q.push_back({3'b100, k[i]});
        end
        exp_cnt = exp_q.size();
    endtask

    task automatic dp_reset();
        dp_hang = 1'b0;
        dp_cnt  = 0;
        ec_rdy  = 1'b1;
    endtask

    // EC datapath: busy for a latency after each command strobe; may hang.
    initial begin
        bit fire;
        int lat;
        forever begin
            @(negedge clk);
            fire = ec_en;
            @(posedge clk);
            #1;
            if (fire) begin
                lat = dp_rand ? $urandom_range(0, 4) : 3;
                if (lat == 0 && !dp_hang) ec_rdy = 1'b1;
                else begin
                    ec_rdy = 1'b0;
                    dp_cnt = lat;
                end
            end else if (dp_cnt > 0) begin
                dp_cnt--;
                if (dp_cnt == 0 && !dp_hang) ec_rdy = 1'b1;
            end
        end
    end

    // Per-cycle compare against the model.
    initial begin
        logic [3:0] e;
        forever begin
            @(negedge clk);
            chk("rdy_vs_busy", rdy, !busy);
            if (!busy) begin
                chk("idle_ec_op", ec_op, 3'b000);
                chk("idle_ec_en", ec_en, 1'b0);
            end
            if (active) begin
                if (busy) chk("op_cnt_track", op_cnt, issued);
                if (ec_en) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_cmd: got op %0d, no command expected", ec_op);
                    end else begin
                        e = exp_q.pop_front();
                        chk("cmd_op", ec_op, e[3:1]);
                        chk("cmd_commit", ec_commit, e[0]);
                    end
                    issued++;
                end
                if (acc_init) got_init++;
                if (done) begin
                    done_cnt++;
                    chk("done_err", err, exp_err);
                    chk("done_op_cnt", op_cnt, exp_cnt);
                    chk("done_cmds_left", exp_q.size(), 0);
                    chk("done_acc_init", got_init, exp_init);
                end
            end
        end
    end

    task automatic launch(input logic [KW-1:0] k, input logic ct, input bit hang);
        build(k, ct);
        if (hang) begin
            while (exp_q.size() > 1) void'(exp_q.pop_back());
            exp_cnt = 1;
            exp_err = 1'b1;
        end
        issued   = 0;
        got_init = 0;
        done_cnt = 0;
        dp_hang  = hang;
        k_in     = k;
        ct_mode  = ct;
        start    = 1'b1;
        active   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int first_en);
        cyc      = 0;
        first_en = -1;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (ec_en && first_en < 0) first_en = cyc;
            if (done) break;
            if (cyc > 3000) begin
                checks++;
                errors++;
                $display("FAIL done_timeout: got no done after %0d cycles, required done", cyc);
                break;
            end
        end
        @(posedge clk);
        #1 active = 1'b0;
        chk("done_once", done_cnt, 1);
    endtask

    task automatic run(input logic [KW-1:0] k, input logic ct, output int cyc);
        int fe;
        launch(k, ct, 1'b0);
        wait_done(cyc, fe);
    endtask

    initial begin
        int cyc, fe, mask, top_pat;
        logic [KW-1:0] kr;
        logic          cr;

        rst = 1'b1; start = 1'b0; clr = 1'b0; ct_mode = 1'b0; k_in = '0; ec_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rdy", rdy, 1); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_err", err, 0); chk("rst_op_cnt", op_cnt, 0); chk("rst_bit_idx", bit_idx, 0);
        chk("rst_acc_init", acc_init, 0); chk("rst_ec_en", ec_en, 0);

        // pin the model to hand-derived values
        build(8'hB4, 1'b0);
        chk("model_b4_cnt", exp_cnt, 10);
        mask = 0;
        foreach (exp_q[i]) mask = (mask << 1) | int'(exp_q[i][3:1] == 3'b100);
        chk("model_b4_seq", mask, 32'b0010100100);
        build(8'hB4, 1'b1);
        chk("model_b4ct_cnt", exp_cnt, 14);
        mask = 0;
        foreach (exp_q[i]) if (exp_q[i][3:1] == 3'b100) mask = (mask << 1) | int'(exp_q[i][0]);
        chk("model_b4ct_commit", mask, 32'b0110100);
        @(posedge clk); #1;

        run(8'hB4, 1'b0, cyc);
        @(negedge clk);
        chk("b4_op_cnt_hold", op_cnt, 10); chk("b4_err", err, 0);

        run(8'hB4, 1'b1, cyc);
        @(negedge clk);
        chk("b4ct_op_cnt_hold", op_cnt, 14); chk("b4ct_err", err, 0);

        run(8'h01, 1'b0, cyc);
        chk("k01_latency", cyc, 10); chk("k01_issued", issued, 0);

        run(8'h00, 1'b0, cyc);
        chk("k00_latency", cyc, 1);
        @(negedge clk);
        chk("k00_err_sticky", err, 1);

        run(8'h7F, 1'b1, cyc);
        chk("k7f_ct_latency", cyc, 1);

        // watchdog: datapath never completes the first doubling
        launch(8'hB4, 1'b0, 1'b1);
        wait_done(cyc, fe);
        chk("wd_latency", cyc - fe, TO + 1);
        @(negedge clk);
        chk("wd_err_sticky", err, 1);
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        dp_reset();
        @(negedge clk);
        chk("wd_clr_err", err, 0); chk("wd_clr_op_cnt", op_cnt, 0);
        @(posedge clk); #1;
        run(8'hB4, 1'b0, cyc);
        @(negedge clk);
        chk("after_wd_op_cnt", op_cnt, 10);

        // clr in ADD_WAIT with a concurrent start
        @(posedge clk); #1;
        launch(8'hB4, 1'b0, 1'b0);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(ec_en && ec_op == 3'b100) && cyc < 500);
        chk("clr_found_add", ec_op, 3'b100);
        @(posedge clk); #1;
        active = 1'b0; clr = 1'b1; start = 1'b1; k_in = 8'hFF;
        @(negedge clk);
        chk("clr_cycle_ec_en", ec_en, 0);
        @(posedge clk); #1 clr = 1'b0; start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("clr_rdy", rdy, 1); chk("clr_done", done, 0); chk("clr_op_cnt", op_cnt, 0);
            chk("clr_err", err, 0); chk("clr_bit_idx", bit_idx, 0);
        end
        dp_reset();

        // rst mid-operation
        @(posedge clk); #1;
        launch(8'hB4, 1'b1, 1'b0);
        repeat (12) @(negedge clk);
        @(posedge clk); #1 active = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        dp_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mid_rdy", rdy, 1); chk("rst_mid_done", done, 0);
            chk("rst_mid_op_cnt", op_cnt, 0); chk("rst_mid_err", err, 0);
        end

        // randomized scalars and datapath latencies
        dp_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            kr = KW'($urandom);
            cr = 1'($urandom);
            top_pat = $urandom_range(0, 3);
            if (top_pat == 0) kr[KW-1] = 1'b1;
            if (top_pat == 1) kr = kr >> $urandom_range(1, KW);
            run(kr, cr, cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
